// File: rtl/sd_block_writer.sv
// -----------------------------------------------------------------------------
// sd_block_writer
//   Drains a capture FIFO into sd_controller's write port, one full SD block at
//   a time. Blocks are written at consecutive addresses from start_adr up to
//   (but not including) stop_adr. A block is only started once the FIFO
//   already holds a complete block, so the controller is never starved mid-block.
//
// Ports
//   clk, reset              clock (clk_25mhz domain), synchronous active-high reset
//   start                   one-cycle pulse, begins a session (IDLE only)
//   halt_req                finish the block in flight, then end the session
//   start_adr, stop_adr     first block address / exclusive end address
//   fifo_dout, fifo_count   FIFO read data (valid 1 cycle after a pop) / occupancy
//   fifo_rd_en              single-cycle FIFO pop
//   sd_ready                controller idle
//   sd_ready_for_next_byte  controller has consumed sd_din (level, may stay high)
//   sd_wr, sd_din, sd_adr   write request, data byte, block address
//   busy, done, error       session status
//   blocks_written          blocks completed in the current session
// -----------------------------------------------------------------------------
module sd_block_writer #(
  parameter int BLOCK_BYTES = 512,
  parameter int CNT_W       = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt_req,
  input  logic [31:0]      start_adr,
  input  logic [31:0]      stop_adr,
  input  logic [7:0]       fifo_dout,
  input  logic [CNT_W-1:0] fifo_count,
  output logic             fifo_rd_en,
  input  logic             sd_ready,
  input  logic             sd_ready_for_next_byte,
  output logic             sd_wr,
  output logic [7:0]       sd_din,
  output logic [31:0]      sd_adr,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [15:0]      blocks_written
);

  localparam int BC_W  = $clog2(BLOCK_BYTES) + 1;
  localparam int OFS_W = $clog2(BLOCK_BYTES);

  localparam logic [CNT_W-1:0] BLK_CNT   = CNT_W'(BLOCK_BYTES);
  localparam logic [BC_W-1:0]  LAST_BYTE = BC_W'(BLOCK_BYTES - 1);
  localparam logic [31:0]      ADR_STEP  = 32'(BLOCK_BYTES);
  localparam logic [32:0]      TWO_STEPS = 33'(2 * BLOCK_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DAT,
    S_PREF,
    S_LOAD,
    S_ISSUE,
    S_FEED,
    S_FIN,
    S_DONE
  } state_t;

  state_t            r_state,      w_state;
  logic [31:0]       r_stop_adr,   w_stop_adr;
  logic [31:0]       r_sd_adr,     w_sd_adr;
  logic [15:0]       r_blocks,     w_blocks;
  logic [BC_W-1:0]   r_byte_cnt,   w_byte_cnt;
  logic              r_rd_en,      w_rd_en;
  logic              r_rd_d1;
  logic              r_sd_wr,      w_sd_wr;
  logic [7:0]        r_sd_din,     w_sd_din;
  logic              r_done,       w_done;
  logic              r_error,      w_error;
  logic              r_halt_pend,  w_halt_pend;
  logic              r_rfnb_last;

  logic              w_busy;
  logic              w_rfnb_rise;
  logic              w_bad_range;
  logic              w_halt;
  logic [32:0]       w_next_end;

  assign w_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_rfnb_rise = sd_ready_for_next_byte & ~r_rfnb_last;
  assign w_bad_range = (start_adr >= stop_adr) ||
                       (|start_adr[OFS_W-1:0]) || (|stop_adr[OFS_W-1:0]);
  assign w_halt      = halt_req | r_halt_pend;
  // End address of the block after the one just finished; 33 bits so a
  // session ending near the top of the address space cannot wrap.
  assign w_next_end  = {1'b0, r_sd_adr} + TWO_STEPS;

  always_comb begin
    w_state     = r_state;
    w_stop_adr  = r_stop_adr;
    w_sd_adr    = r_sd_adr;
    w_blocks    = r_blocks;
    w_byte_cnt  = r_byte_cnt;
    w_rd_en     = 1'b0;
    w_sd_wr     = r_sd_wr;
    w_done      = 1'b0;
    w_error     = r_error;
    // A halt request mid-block is remembered and honoured at the block end.
    w_halt_pend = r_halt_pend | (halt_req & w_busy);
    // Every pop lands in sd_din the cycle after the FIFO presents it; with no
    // pop, sd_din simply holds.
    w_sd_din    = r_rd_d1 ? fifo_dout : r_sd_din;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_stop_adr  = stop_adr;
          w_sd_adr    = start_adr;
          w_blocks    = 16'd0;
          w_error     = 1'b0;
          w_halt_pend = 1'b0;
          if (w_bad_range) begin
            w_error = 1'b1;
            w_done  = 1'b1;
          end else begin
            w_state = S_WAIT_DAT;
          end
        end
      end

      S_WAIT_DAT: begin
        if (w_halt) begin
          w_state = S_DONE;
          w_done  = 1'b1;
        end else if ((fifo_count >= BLK_CNT) && sd_ready) begin
          w_state    = S_PREF;
          w_rd_en    = 1'b1;
          w_byte_cnt = '0;
        end
      end

      // Byte 0 is popped here and lands in sd_din during LOAD.
      S_PREF:  w_state = S_LOAD;

      S_LOAD: begin
        w_state = S_ISSUE;
        w_sd_wr = 1'b1;
      end

      S_ISSUE: begin
        if (!sd_ready) begin
          w_sd_wr = 1'b0;
          w_state = S_FEED;
        end
      end

      S_FEED: begin
        if (w_rfnb_rise) begin
          w_byte_cnt = r_byte_cnt + 1'b1;
          if (r_byte_cnt < LAST_BYTE) begin
            // Full block was buffered before starting, so an empty FIFO here
            // means something upstream broke; keep the old byte and flag it.
            if (fifo_count == '0) begin
              w_error = 1'b1;
            end else begin
              w_rd_en = 1'b1;
            end
          end else begin
            w_state = S_FIN;
          end
        end
      end

      S_FIN: begin
        if (sd_ready) begin
          w_blocks = r_blocks + 16'd1;
          w_sd_adr = r_sd_adr + ADR_STEP;
          if ((w_next_end > {1'b0, r_stop_adr}) || w_halt) begin
            w_state = S_DONE;
            w_done  = 1'b1;
          end else begin
            w_state = S_WAIT_DAT;
          end
        end
      end

      S_DONE: begin
        w_state     = S_IDLE;
        w_halt_pend = 1'b0;
      end

      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_stop_adr  <= '0;
      r_sd_adr    <= '0;
      r_blocks    <= '0;
      r_byte_cnt  <= '0;
      r_rd_en     <= 1'b0;
      r_rd_d1     <= 1'b0;
      r_sd_wr     <= 1'b0;
      r_sd_din    <= '0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_halt_pend <= 1'b0;
      r_rfnb_last <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_stop_adr  <= w_stop_adr;
      r_sd_adr    <= w_sd_adr;
      r_blocks    <= w_blocks;
      r_byte_cnt  <= w_byte_cnt;
      r_rd_en     <= w_rd_en;
      r_rd_d1     <= r_rd_en;
      r_sd_wr     <= w_sd_wr;
      r_sd_din    <= w_sd_din;
      r_done      <= w_done;
      r_error     <= w_error;
      r_halt_pend <= w_halt_pend;
      r_rfnb_last <= sd_ready_for_next_byte;
    end
  end

  assign fifo_rd_en     = r_rd_en;
  assign sd_wr          = r_sd_wr;
  assign sd_din         = r_sd_din;
  assign sd_adr         = r_sd_adr;
  assign busy           = w_busy;
  assign done           = r_done;
  assign error          = r_error;
  assign blocks_written = r_blocks;

endmodule

// File: tb/tb_sd_block_writer.sv
// -----------------------------------------------------------------------------
// tb_sd_block_writer
//   Directed bench for sd_block_writer. A FIFO model and an sd_controller
//   write-port model surround the DUT; stimulus pushes expected bytes,
//   addresses and session results into queues, and the controller/done
//   monitors pop and compare as the DUT produces them.
// -----------------------------------------------------------------------------
module tb_sd_block_writer;

  localparam int BB = 512;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        halt_req;
  logic [31:0] start_adr;
  logic [31:0] stop_adr;
  logic [7:0]  fifo_dout;
  logic [13:0] fifo_count;
  logic        fifo_rd_en;
  logic        sd_ready;
  logic        sd_rfnb;
  logic        sd_wr;
  logic [7:0]  sd_din;
  logic [31:0] sd_adr;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] blocks_written;

  always #5 clk = ~clk;

  sd_block_writer #(.BLOCK_BYTES(BB), .CNT_W(14)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .start                  (start),
    .halt_req               (halt_req),
    .start_adr              (start_adr),
    .stop_adr               (stop_adr),
    .fifo_dout              (fifo_dout),
    .fifo_count             (fifo_count),
    .fifo_rd_en             (fifo_rd_en),
    .sd_ready               (sd_ready),
    .sd_ready_for_next_byte (sd_rfnb),
    .sd_wr                  (sd_wr),
    .sd_din                 (sd_din),
    .sd_adr                 (sd_adr),
    .busy                   (busy),
    .done                   (done),
    .error                  (error),
    .blocks_written         (blocks_written)
  );

  int checks   = 0;
  int failures = 0;
  int n_cons   = 0;   // bytes consumed by the controller model
  int n_pops   = 0;   // FIFO pops seen
  int n_wr     = 0;   // write requests accepted
  int n_done   = 0;   // done pulses seen
  int hi_cyc   = 1;   // ready_for_next_byte high time per byte
  int lo_cyc   = 3;   // ready_for_next_byte low time per byte

  logic [7:0]  pend[$];     // bytes waiting to enter the FIFO model
  logic [7:0]  fq[$];       // FIFO model contents
  logic [7:0]  byte_q[$];   // expected bytes in write order
  logic [31:0] adr_q[$];    // expected write addresses
  logic [16:0] done_q[$];   // expected {error, blocks_written} at done

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, req, $time);
    end
  endtask

  // ---------------- FIFO model (read data valid one cycle after the pop) ----
  initial begin : fifo_model
    logic       pop_pend;
    logic [7:0] popped;
    pop_pend   = 1'b0;
    popped     = 8'd0;
    fifo_dout  = 8'd0;
    fifo_count = 14'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        fq.delete();
        pend.delete();
        pop_pend = 1'b0;
      end else begin
        if (pop_pend) fifo_dout = popped;
        pop_pend = 1'b0;
        while (pend.size() != 0) fq.push_back(pend.pop_front());
        if (fifo_rd_en === 1'b1) begin
          chk("pop_not_empty", 64'(fq.size() != 0), 64'd1);
          if (fq.size() != 0) begin
            popped   = fq.pop_front();
            pop_pend = 1'b1;
            n_pops++;
          end
        end
      end
      fifo_count = 14'(fq.size());
    end
  end

  // ---------------- sd_controller write-port model + byte/address checker --
  initial begin : ctrl_model
    int          c_st;
    int          c_cnt;
    int          c_byte;
    int          c_phase;
    logic [31:0] ea;
    logic [7:0]  eb;
    c_st = 0; c_cnt = 0; c_byte = 0; c_phase = 0;
    sd_ready = 1'b1;
    sd_rfnb  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        c_st     = 0;
        sd_ready = 1'b1;
        sd_rfnb  = 1'b0;
      end else begin
        case (c_st)
          0: begin
            if (sd_wr === 1'b1 && sd_ready) begin
              n_wr++;
              $display("WR   t=%0t adr=0x%08h", $time, sd_adr);
              chk("wr_expected", 64'(adr_q.size() != 0), 64'd1);
              if (adr_q.size() != 0) begin
                ea = adr_q.pop_front();
                chk("wr_adr", 64'(sd_adr), 64'(ea));
              end
              sd_ready = 1'b0;
              c_st     = 1;
              c_cnt    = 0;
            end
          end
          1: begin
            c_cnt++;
            if (c_cnt == 3) begin
              c_st = 2; c_byte = 0; c_phase = 0;
            end
          end
          2: begin
            if (c_phase == 0) begin
              sd_rfnb = 1'b1;
              n_cons++;
              chk("byte_expected", 64'(byte_q.size() != 0), 64'd1);
              if (byte_q.size() != 0) begin
                eb = byte_q.pop_front();
                chk("wr_byte", 64'(sd_din), 64'(eb));
              end
            end else if (c_phase == hi_cyc) begin
              sd_rfnb = 1'b0;
            end
            c_phase++;
            if (c_phase == hi_cyc + lo_cyc) begin
              c_phase = 0;
              c_byte++;
              if (c_byte == BB) begin
                c_st = 3; c_cnt = 0;
              end
            end
          end
          default: begin
            c_cnt++;
            if (c_cnt == 3) begin
              sd_ready = 1'b1;
              c_st     = 0;
            end
          end
        endcase
      end
    end
  end

  // ---------------- session-end monitor ----------------
  initial begin : done_mon
    logic [16:0] ed;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && done === 1'b1) begin
        n_done++;
        $display("DONE t=%0t blocks=%0d error=%0b", $time, blocks_written, error);
        chk("done_expected", 64'(done_q.size() != 0), 64'd1);
        if (done_q.size() != 0) begin
          ed = done_q.pop_front();
          chk("done_error", 64'(error), 64'(ed[16]));
          chk("done_blocks", 64'(blocks_written), 64'(ed[15:0]));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    start    = 1'b0;
    halt_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    byte_q.delete();
    adr_q.delete();
    done_q.delete();
    tick();
  endtask

  task automatic push_ramp(input int n, input int base);
    for (int i = 0; i < n; i++) pend.push_back(8'(base + i));
  endtask

  task automatic exp_ramp(input int n, input int base);
    for (int i = 0; i < n; i++) byte_q.push_back(8'(base + i));
  endtask

  task automatic start_session(input logic [31:0] s, input logic [31:0] e);
    start_adr = s;
    stop_adr  = e;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int target);
    int k;
    k = 0;
    while (n_done < target && k < 20000) begin
      tick();
      k++;
    end
    chk(nm, 64'(n_done), 64'(target));
    tick();
    tick();
  endtask

  task automatic wait_cons(input string nm, input int target);
    int k;
    k = 0;
    while (n_cons < target && k < 5000) begin
      tick();
      k++;
    end
    chk(nm, 64'(n_cons >= target), 64'd1);
  endtask

  task automatic chk_drained(input string tag);
    chk({tag, "_bytes_left"}, 64'(byte_q.size()), 64'd0);
    chk({tag, "_adrs_left"},  64'(adr_q.size()),  64'd0);
    chk({tag, "_dones_left"}, 64'(done_q.size()), 64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=running required=finished t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed tests ----------------
  initial begin : stim
    int done_tgt;
    int pops0;
    int wr0;
    int cons0;
    int lat;
    int k;

    reset     = 1'b1;
    start     = 1'b0;
    halt_req  = 1'b0;
    start_adr = 32'd0;
    stop_adr  = 32'd0;
    done_tgt  = 0;

    // Reset state
    do_reset();
    chk("rst_sd_wr",      64'(sd_wr),          64'd0);
    chk("rst_fifo_rd_en", 64'(fifo_rd_en),     64'd0);
    chk("rst_sd_din",     64'(sd_din),         64'd0);
    chk("rst_sd_adr",     64'(sd_adr),         64'd0);
    chk("rst_busy",       64'(busy),           64'd0);
    chk("rst_done",       64'(done),           64'd0);
    chk("rst_error",      64'(error),          64'd0);
    chk("rst_blocks",     64'(blocks_written), 64'd0);

    // 1: two blocks 0x1000, 0x1200 from a 1024-byte ramp
    pops0 = n_pops; wr0 = n_wr;
    push_ramp(1024, 0);
    exp_ramp(1024, 0);
    adr_q.push_back(32'h0000_1000);
    adr_q.push_back(32'h0000_1200);
    done_q.push_back({1'b0, 16'd2});
    done_tgt++;
    start_session(32'h0000_1000, 32'h0000_1400);
    chk("t1_busy", 64'(busy), 64'd1);
    wait_done("t1_done_seen", done_tgt);
    chk("t1_pops",   64'(n_pops - pops0), 64'd1024);
    chk("t1_writes", 64'(n_wr - wr0),     64'd2);
    chk("t1_blocks", 64'(blocks_written), 64'd2);
    chk("t1_idle",   64'(busy),           64'd0);
    chk_drained("t1");

    // 4: empty range, then misaligned start
    wr0 = n_wr;
    done_q.push_back({1'b1, 16'd0});
    done_tgt++;
    start_session(32'h0000_1000, 32'h0000_1000);
    wait_done("t4a_done_seen", done_tgt);
    chk("t4a_error", 64'(error), 64'd1);
    chk("t4a_busy",  64'(busy),  64'd0);
    done_q.push_back({1'b1, 16'd0});
    done_tgt++;
    start_session(32'h0000_1010, 32'h0000_2000);
    wait_done("t4b_done_seen", done_tgt);
    chk("t4b_error",  64'(error),       64'd1);
    chk("t4b_sd_adr", 64'(sd_adr),      64'h1010);
    chk("t4_no_wr",   64'(n_wr - wr0),  64'd0);
    chk_drained("t4");

    // 2: 511 bytes is not enough; the 512th starts the block
    wr0 = n_wr; pops0 = n_pops;
    push_ramp(511, 0);
    exp_ramp(512, 0);
    adr_q.push_back(32'h0000_0000);
    done_q.push_back({1'b0, 16'd1});
    done_tgt++;
    start_session(32'h0000_0000, 32'h0000_0200);
    chk("t2_error_cleared", 64'(error), 64'd0);
    repeat (20) tick();
    chk("t2_no_wr_511",  64'(n_wr - wr0),     64'd0);
    chk("t2_no_pop_511", 64'(n_pops - pops0), 64'd0);
    chk("t2_waiting",    64'(busy),           64'd1);
    pend.push_back(8'hFF);
    k = 0;
    do begin
      @(negedge clk); #1;
      k++;
    end while (fifo_count != 14'd512 && k < 5);
    chk("t2_count_512", 64'(fifo_count), 64'd512);
    lat = 0;
    while (fifo_rd_en !== 1'b1 && lat < 6) begin
      @(negedge clk); #1;
      lat++;
    end
    chk("t2_start_latency", 64'(lat <= 3), 64'd1);
    tick();
    wait_done("t2_done_seen", done_tgt);
    chk("t2_pops",   64'(n_pops - pops0), 64'd512);
    chk("t2_blocks", 64'(blocks_written), 64'd1);
    chk_drained("t2");

    // 3: ready_for_next_byte held high 4 cycles per byte
    hi_cyc = 4; lo_cyc = 2;
    cons0 = n_cons; pops0 = n_pops;
    push_ramp(512, 8'h40);
    exp_ramp(512, 8'h40);
    adr_q.push_back(32'h0000_0000);
    done_q.push_back({1'b0, 16'd1});
    done_tgt++;
    start_session(32'h0000_0000, 32'h0000_0200);
    wait_done("t3_done_seen", done_tgt);
    chk("t3_consumed", 64'(n_cons - cons0), 64'd512);
    chk("t3_pops",     64'(n_pops - pops0), 64'd512);
    chk_drained("t3");
    hi_cyc = 1; lo_cyc = 3;

    // 5: halt at byte 100 of block 0 finishes that block only
    do_reset();
    pops0 = n_pops; cons0 = n_cons; wr0 = n_wr;
    push_ramp(1024, 0);
    exp_ramp(512, 0);
    adr_q.push_back(32'h0000_1000);
    done_q.push_back({1'b0, 16'd1});
    done_tgt++;
    start_session(32'h0000_1000, 32'h0000_2000);
    wait_cons("t5_reach_100", cons0 + 100);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    wait_done("t5_done_seen", done_tgt);
    chk("t5_pops",   64'(n_pops - pops0), 64'd512);
    chk("t5_writes", 64'(n_wr - wr0),     64'd1);
    chk("t5_blocks", 64'(blocks_written), 64'd1);
    chk_drained("t5");

    // 6: reset at byte 300 abandons the block; restart is clean
    do_reset();
    cons0 = n_cons;
    push_ramp(1024, 0);
    exp_ramp(1024, 0);
    adr_q.push_back(32'h0000_0000);
    start_session(32'h0000_0000, 32'h0000_0400);
    wait_cons("t6_reach_300", cons0 + 300);
    reset = 1'b1;
    tick();
    chk("t6_rst_sd_wr",  64'(sd_wr),      64'd0);
    chk("t6_rst_busy",   64'(busy),       64'd0);
    chk("t6_rst_rd_en",  64'(fifo_rd_en), 64'd0);
    chk("t6_rst_blocks", 64'(blocks_written), 64'd0);
    reset = 1'b0;
    byte_q.delete();
    adr_q.delete();
    done_q.delete();
    pops0 = n_pops; wr0 = n_wr;
    repeat (10) tick();
    chk("t6_no_pop_after_rst", 64'(n_pops - pops0), 64'd0);
    chk("t6_no_wr_after_rst",  64'(n_wr - wr0),     64'd0);
    push_ramp(512, 8'h80);
    exp_ramp(512, 8'h80);
    adr_q.push_back(32'h0000_0000);
    done_q.push_back({1'b0, 16'd1});
    done_tgt++;
    start_session(32'h0000_0000, 32'h0000_0200);
    wait_done("t6_done_seen", done_tgt);
    chk("t6_pops",   64'(n_pops - pops0), 64'd512);
    chk("t6_blocks", 64'(blocks_written), 64'd1);
    chk_drained("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
